devil_pattern_monitor: RTL and testbench

Passive tap on the ACE snoop-data (CD) channel that reassembles 4-beat cache lines and compares them against the 512-bit pattern supplied by `devil_controller` (`o_cache_line_2_monitor`). On a full-line match it emits a one-cycle trigger into the controller's `i_trigger` and reports the matching snoop address. It then holds off until the controller finishes its operation. It is the consumer/initiator side of the controller's pattern/trigger interface and never drives the ACE channels.

---
 rtl/devil_pattern_monitor.sv | 128 ++++++++++++
 tb/tb_devil_pattern_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/devil_pattern_monitor.sv
// Passive CD-channel tap: reassembles 4-beat snoop-data lines, compares them with the
// controller's 512-bit pattern and pulses o_trigger (plus match address/count) on a full match.
module devil_pattern_monitor #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int DEVIL_STATE_SIZE = 5
) (
    input  logic                          ace_aclk,
    input  logic                          ace_aresetn,
    input  logic                          i_enable,
    input  logic [4*C_ACE_DATA_WIDTH-1:0] i_pattern,
    input  logic                          i_acvalid,
    input  logic                          i_acready,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
    input  logic                          i_cdvalid,
    input  logic                          i_cdready,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
    input  logic                          i_cdlast,
    input  logic [DEVIL_STATE_SIZE-1:0]   i_fsm_devil_controller,
    output logic                          o_trigger,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_match_addr,
    output logic [15:0]                   o_match_count,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        MON_IDLE,
        MON_BEAT,
        MON_DRAIN,
        MON_FIRE,
        MON_HOLD
    } mon_state_t;

    localparam logic [DEVIL_STATE_SIZE-1:0] CTRL_END_OP = DEVIL_STATE_SIZE'(5);

    mon_state_t                                state;
    logic [1:0]                                beat_cnt;
    logic                                      match_q;
    logic                                      burst_open_q;
    logic [C_ACE_ADDR_WIDTH-1:0]               ac_addr_q;
    logic [C_ACE_ADDR_WIDTH-1:0]               line_addr_q;
    logic [15:0]                               match_cnt_q;
    logic [3:0][C_ACE_DATA_WIDTH-1:0]          pat_beats;
    logic [1:0]                                cur_idx;
    logic                                      ac_xfer;
    logic                                      cd_beat;
    logic                                      beat_hit;
    logic                                      line_hit;

    assign ac_xfer   = i_acvalid & i_acready;
    assign cd_beat   = i_cdvalid & i_cdready;
    assign pat_beats = i_pattern;
    // Leaving MON_BEAT does not clear beat_cnt in the same edge, so IDLE always compares beat 0.
    assign cur_idx   = (state == MON_BEAT) ? beat_cnt : 2'd0;
    assign beat_hit  = (i_cddata == pat_beats[cur_idx]);
    assign line_hit  = match_q & beat_hit;

    assign o_match_count = match_cnt_q;
    assign o_busy        = (state != MON_IDLE);

    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            state        <= MON_IDLE;
            beat_cnt     <= 2'd0;
            match_q      <= 1'b1;
            burst_open_q <= 1'b0;
            ac_addr_q    <= '0;
            line_addr_q  <= '0;
            match_cnt_q  <= '0;
            o_trigger    <= 1'b0;
            o_match_addr <= '0;
        end else begin
            o_trigger <= 1'b0;
            if (ac_xfer) ac_addr_q <= i_acaddr;
            // Tracks burst boundaries in every state so a burst begun while busy is never
            // mistaken for a fresh line once the monitor returns to idle.
            if (cd_beat) burst_open_q <= ~i_cdlast;

            case (state)
                MON_IDLE: begin
                    beat_cnt <= 2'd0;
                    match_q  <= 1'b1;
                    if (cd_beat && i_enable && !burst_open_q) begin
                        line_addr_q <= ac_addr_q;
                        if (i_cdlast) begin
                            state <= MON_IDLE;
                        end else if (!beat_hit) begin
                            state <= MON_DRAIN;
                        end else begin
                            beat_cnt <= 2'd1;
                            state    <= MON_BEAT;
                        end
                    end
                end
                MON_BEAT: begin
                    if (!i_enable) begin
                        state <= MON_IDLE;
                    end else if (cd_beat) begin
                        if (beat_cnt == 2'd0) line_addr_q <= ac_addr_q;
                        match_q  <= line_hit;
                        beat_cnt <= beat_cnt + 2'd1;
                        if (i_cdlast) begin
                            if (beat_cnt == 2'd3 && line_hit) begin
                                state        <= MON_FIRE;
                                o_trigger    <= 1'b1;
                                o_match_addr <= line_addr_q;
                                if (match_cnt_q != 16'hFFFF) match_cnt_q <= match_cnt_q + 16'd1;
                            end else begin
                                state <= MON_IDLE;
                            end
                        end else if (beat_cnt == 2'd3 || !line_hit) begin
                            state <= MON_DRAIN;
                        end
                    end
                end
                MON_DRAIN: begin
                    if (!i_enable || (cd_beat && i_cdlast)) state <= MON_IDLE;
                end
                MON_FIRE: state <= MON_HOLD;
                MON_HOLD: begin
                    if (i_fsm_devil_controller == CTRL_END_OP) state <= MON_IDLE;
                end
                default: state <= MON_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_devil_pattern_monitor.sv
// Scoreboard bench for devil_pattern_monitor: directed bursts push expected triggers,
// a negedge monitor pops and checks cycle, address and count of every trigger seen.
module tb_devil_pattern_monitor;

    localparam logic [127:0] B0 = 128'hfe16863c_bbaf7e47_dcd5db54_d54783c2;
    localparam logic [127:0] B1 = 128'hcd197260_f65b9c92_d260d0b8_d206ceac;
    localparam logic [127:0] B2 = 128'h1cd9b232_893d8de5_1443e896_fcb01399;
    localparam logic [127:0] B3 = 128'heb624e0d_ff78efa1_1ec5cf46_c8772659;

    logic         ace_aclk = 1'b0;
    logic         ace_aresetn;
    logic         i_enable;
    logic [511:0] i_pattern;
    logic         i_acvalid, i_acready;
    logic [43:0]  i_acaddr;
    logic         i_cdvalid, i_cdready;
    logic [127:0] i_cddata;
    logic         i_cdlast;
    logic [4:0]   i_fsm_devil_controller;
    logic         o_trigger;
    logic [43:0]  o_match_addr;
    logic [15:0]  o_match_count;
    logic         o_busy;

    devil_pattern_monitor dut (
        .ace_aclk               (ace_aclk),
        .ace_aresetn            (ace_aresetn),
        .i_enable               (i_enable),
        .i_pattern              (i_pattern),
        .i_acvalid              (i_acvalid),
        .i_acready              (i_acready),
        .i_acaddr               (i_acaddr),
        .i_cdvalid              (i_cdvalid),
        .i_cdready              (i_cdready),
        .i_cddata               (i_cddata),
        .i_cdlast               (i_cdlast),
        .i_fsm_devil_controller (i_fsm_devil_controller),
        .o_trigger              (o_trigger),
        .o_match_addr           (o_match_addr),
        .o_match_count          (o_match_count),
        .o_busy                 (o_busy)
    );

    always #5 ace_aclk = ~ace_aclk;

    typedef struct {
        int          cyc;
        logic [43:0] addr;
        logic [15:0] cnt;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_cyc = 0;
    logic [15:0]  exp_cnt = 16'd0;
    logic [127:0] pat [4];
    logic         prev_trig = 1'b0;

    always @(posedge ace_aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every trigger must be expected, single-cycle, on time, with the right payload.
    always @(negedge ace_aclk) begin
        if (o_trigger) begin
            if (prev_trig) chk("trigger_width", 64'd2, 64'd1);
            else if (sb.size() == 0) chk("unexpected_trigger", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("trigger_cycle", 64'(cyc), 64'(e.cyc));
                chk("match_addr", 64'(o_match_addr), 64'(e.addr));
                chk("match_count", 64'(o_match_count), 64'(e.cnt));
            end
        end
        prev_trig = o_trigger;
    end

    task automatic tick();
        @(posedge ace_aclk);
        #1;
    endtask

    task automatic beat(input logic [127:0] d, input logic l);
        i_cdvalid = 1'b1; i_cdready = 1'b1; i_cddata = d; i_cdlast = l;
        tick();
        last_cyc  = cyc;
        i_cdvalid = 1'b0; i_cdready = 1'b0; i_cdlast = 1'b0;
    endtask

    // n beats, last on beat n-1; optional ready stall before each beat after the first.
    task automatic send_burst(input int n, input int stall, input logic flip2);
        for (int k = 0; k < n; k++) begin
            logic [127:0] d;
            d = pat[k % 4];
            if (flip2 && k == 2) d = d ^ 128'h1;
            if (k > 0) begin
                for (int s = 0; s < stall; s++) begin
                    i_cdvalid = 1'b1; i_cdready = 1'b0; i_cddata = d; i_cdlast = (k == n - 1);
                    tick();
                end
            end
            beat(d, (k == n - 1));
        end
    endtask

    task automatic ac_xfer(input logic [43:0] a);
        i_acvalid = 1'b1; i_acready = 1'b1; i_acaddr = a;
        tick();
        i_acvalid = 1'b0; i_acready = 1'b0;
    endtask

    task automatic expect_trig(input logic [43:0] a);
        exp_t e;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.cyc = last_cyc; e.addr = a; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic ctrl_finish();
        i_fsm_devil_controller = 5'd1; tick();
        i_fsm_devil_controller = 5'd2; tick();
        i_fsm_devil_controller = 5'd5; tick();
        i_fsm_devil_controller = 5'd0; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        pat[0] = B0; pat[1] = B1; pat[2] = B2; pat[3] = B3;
        i_pattern = {B3, B2, B1, B0};
        ace_aresetn = 1'b0; i_enable = 1'b1;
        i_acvalid = 1'b0; i_acready = 1'b0; i_acaddr = '0;
        i_cdvalid = 1'b0; i_cdready = 1'b0; i_cddata = '0; i_cdlast = 1'b0;
        i_fsm_devil_controller = 5'd0;
        repeat (3) tick();
        chk("rst_trigger", 64'(o_trigger), 64'd0);
        chk("rst_addr", 64'(o_match_addr), 64'd0);
        chk("rst_count", 64'(o_match_count), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        ace_aresetn = 1'b1;
        tick();

        // Basic match.
        ac_xfer(44'h0_0000_1040);
        send_burst(4, 0, 1'b0);
        expect_trig(44'h1040);
        // Matching line begun during FIRE/HOLD, HOLD exits mid-burst: ignored.
        fork
            send_burst(4, 0, 1'b0);
            ctrl_finish();
        join
        repeat (3) tick();
        chk("hold_burst_ignored_count", 64'(o_match_count), 64'(exp_cnt));
        chk("hold_exit_idle", 64'(o_busy), 64'd0);
        ac_xfer(44'h0_0000_2080);
        send_burst(4, 0, 1'b0);
        expect_trig(44'h2080);
        ctrl_finish();

        // Flipped bit in beat 2: no trigger; stalled correct line: trigger.
        ac_xfer(44'h0_0000_3000);
        send_burst(4, 0, 1'b1);
        tick();
        chk("flip_no_trigger", 64'(o_match_count), 64'(exp_cnt));
        send_burst(4, 3, 1'b0);
        expect_trig(44'h3000);
        ctrl_finish();

        // Short and long bursts never match; monitor back in idle afterwards.
        ac_xfer(44'h0_0000_4000);
        send_burst(3, 0, 1'b0);
        tick();
        chk("short_idle", 64'(o_busy), 64'd0);
        send_burst(5, 0, 1'b0);
        tick();
        chk("long_idle", 64'(o_busy), 64'd0);
        chk("short_long_count", 64'(o_match_count), 64'(exp_cnt));
        send_burst(4, 0, 1'b0);
        expect_trig(44'h4000);
        ctrl_finish();

        // AC transfer coincident with first beat: the line keeps the older address.
        ac_xfer(44'h0_0000_5000);
        i_acvalid = 1'b1; i_acready = 1'b1; i_acaddr = 44'h0_0000_6000;
        beat(B0, 1'b0);
        i_acvalid = 1'b0; i_acready = 1'b0;
        beat(B1, 1'b0); beat(B2, 1'b0); beat(B3, 1'b1);
        expect_trig(44'h5000);
        ctrl_finish();
        send_burst(4, 0, 1'b0);
        expect_trig(44'h6000);
        ctrl_finish();

        // Enable dropped after beat 1: abort, no trigger.
        beat(B0, 1'b0); beat(B1, 1'b0);
        i_enable = 1'b0;
        beat(B2, 1'b0); beat(B3, 1'b1);
        i_enable = 1'b1;
        tick();
        chk("enable_abort_count", 64'(o_match_count), 64'(exp_cnt));
        chk("enable_abort_idle", 64'(o_busy), 64'd0);

        // Reset during beat 2: partial line dropped, everything back to reset values.
        beat(B0, 1'b0); beat(B1, 1'b0);
        ace_aresetn = 1'b0;
        beat(B2, 1'b0); beat(B3, 1'b1);
        ace_aresetn = 1'b1;
        exp_cnt = 16'd0;
        tick();
        chk("rst2_trigger", 64'(o_trigger), 64'd0);
        chk("rst2_addr", 64'(o_match_addr), 64'd0);
        chk("rst2_count", 64'(o_match_count), 64'd0);
        chk("rst2_busy", 64'(o_busy), 64'd0);

        // Saturation: preload the counter just below the ceiling.
        force dut.match_cnt_q = 16'hFFFE;
        tick();
        release dut.match_cnt_q;
        exp_cnt = 16'hFFFE;
        tick();
        chk("preload_count", 64'(o_match_count), 64'hFFFE);
        send_burst(4, 0, 1'b0);
        expect_trig(44'h0);
        ctrl_finish();
        send_burst(4, 0, 1'b0);
        expect_trig(44'h0);
        ctrl_finish();
        repeat (4) tick();
        chk("sat_count", 64'(o_match_count), 64'hFFFF);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
